sha256_compressor: RTL and testbench

- Downstream neighbour of the message-schedule extender. Consumes the 64-word expanded schedule W[0..63] and the incoming hash context.
- Runs the 64 SHA-256 compression rounds iteratively, then adds the working variables to the incoming context. Presents the updated context on a valid/ready output.
- The output context feeds back as the next chunk's context, or is read as the final digest.

---
 rtl/sha256_pkg.sv | 62 ++++++
 rtl/sha256_round.sv | 27 ++
 rtl/sha256_compressor.sv | 135 +++++++++++++
 tb/tb_sha256_compressor.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round helper functions.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ROUNDS = 64;
  localparam int unsigned CNT_W  = 6;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ROUNDS-1:0][WORD_W-1:0] sched_t;

  typedef struct packed {
    word_t h0, h1, h2, h3, h4, h5, h6, h7;
  } ShaContext;

  typedef struct packed {
    word_t a, b, c, d, e, f, g, h;
  } work_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUNDS,
    S_ADD,
    S_OUTPUT
  } state_e;

  localparam ShaContext SHA256_IV = '{
    h0: 32'h6a09e667, h1: 32'hbb67ae85, h2: 32'h3c6ef372, h3: 32'ha54ff53a,
    h4: 32'h510e527f, h5: 32'h9b05688c, h6: 32'h1f83d9ab, h7: 32'h5be0cd19
  };

  localparam word_t K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rightRotate32(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t bigSigma0(input word_t x);
    return rightRotate32(x, 2) ^ rightRotate32(x, 13) ^ rightRotate32(x, 22);
  endfunction

  function automatic word_t bigSigma1(input word_t x);
    return rightRotate32(x, 6) ^ rightRotate32(x, 11) ^ rightRotate32(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t vars_i,
  input  word_t k_i,
  input  word_t w_i,
  output work_t vars_o
);

  word_t t1_c;
  word_t t2_c;

  always_comb begin
    t1_c = vars_i.h + bigSigma1(vars_i.e) + ch(vars_i.e, vars_i.f, vars_i.g) + k_i + w_i;
    t2_c = bigSigma0(vars_i.a) + maj(vars_i.a, vars_i.b, vars_i.c);
    vars_o.a = t1_c + t2_c;
    vars_o.b = vars_i.a;
    vars_o.c = vars_i.b;
    vars_o.d = vars_i.c;
    vars_o.e = vars_i.d + t1_c;
    vars_o.f = vars_i.e;
    vars_o.g = vars_i.f;
    vars_o.h = vars_i.g;
  end

endmodule

// File: rtl/sha256_compressor.sv
// Iterative SHA-256 compression: latch context and schedule, run 64 rounds
// (UNROLL per clock), add back into the context and hand out the result.
module sha256_compressor
  import sha256_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ctx_vld,
  output logic      ctx_rdy,
  input  ShaContext ctx,
  input  logic      w_vld,
  output logic      w_rdy,
  input  sched_t    w,
  output logic      out_vld,
  input  logic      out_rdy,
  output ShaContext out_ctx
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha256_compressor: UNROLL must be 1, 2 or 4");
  end

  state_e           state_q,   state_d;
  logic             ctx_lat_q, ctx_lat_d;
  logic             w_lat_q,   w_lat_d;
  ShaContext        ctx_q,     ctx_d;
  sched_t           w_q,       w_d;
  work_t            vars_q,    vars_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  ShaContext        out_ctx_q, out_ctx_d;

  logic  ctx_xfer_c;
  logic  w_xfer_c;
  work_t chain_c [UNROLL+1];

  // Handshake outputs are decoded from state and held low during reset.
  assign ctx_rdy    = ~rst & (state_q == S_IDLE) & ~ctx_lat_q;
  assign w_rdy      = ~rst & (state_q == S_IDLE) & ~w_lat_q;
  assign out_vld    = ~rst & (state_q == S_OUTPUT);
  assign out_ctx    = rst ? '0 : out_ctx_q;
  assign ctx_xfer_c = ctx_vld & ctx_rdy;
  assign w_xfer_c   = w_vld & w_rdy;

  assign chain_c[0] = vars_q;
  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    logic [CNT_W-1:0] t_c;
    assign t_c = cnt_q + CNT_W'(i);
    sha256_round u_round (
      .vars_i (chain_c[i]),
      .k_i    (K[t_c]),
      .w_i    (w_q[t_c]),
      .vars_o (chain_c[i+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    ctx_lat_d = ctx_lat_q;
    w_lat_d   = w_lat_q;
    ctx_d     = ctx_q;
    w_d       = w_q;
    vars_d    = vars_q;
    cnt_d     = cnt_q;
    out_ctx_d = out_ctx_q;
    unique case (state_q)
      S_IDLE: begin
        if (ctx_xfer_c) begin
          ctx_d     = ctx;
          ctx_lat_d = 1'b1;
        end
        if (w_xfer_c) begin
          w_d     = w;
          w_lat_d = 1'b1;
        end
        // Start as soon as both inputs are held, counting this edge's transfers.
        if (ctx_lat_d && w_lat_d) begin
          state_d = S_ROUNDS;
          vars_d  = work_t'(ctx_d);
          cnt_d   = '0;
        end
      end
      S_ROUNDS: begin
        vars_d = chain_c[UNROLL];
        cnt_d  = cnt_q + CNT_W'(UNROLL);
        if (cnt_q == CNT_W'(ROUNDS - UNROLL)) begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        out_ctx_d.h0 = ctx_q.h0 + vars_q.a;
        out_ctx_d.h1 = ctx_q.h1 + vars_q.b;
        out_ctx_d.h2 = ctx_q.h2 + vars_q.c;
        out_ctx_d.h3 = ctx_q.h3 + vars_q.d;
        out_ctx_d.h4 = ctx_q.h4 + vars_q.e;
        out_ctx_d.h5 = ctx_q.h5 + vars_q.f;
        out_ctx_d.h6 = ctx_q.h6 + vars_q.g;
        out_ctx_d.h7 = ctx_q.h7 + vars_q.h;
        ctx_lat_d    = 1'b0;
        w_lat_d      = 1'b0;
        state_d      = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctx_lat_q <= 1'b0;
      w_lat_q   <= 1'b0;
      ctx_q     <= '0;
      w_q       <= '0;
      vars_q    <= '0;
      cnt_q     <= '0;
      out_ctx_q <= '0;
    end else begin
      state_q   <= state_d;
      ctx_lat_q <= ctx_lat_d;
      w_lat_q   <= w_lat_d;
      ctx_q     <= ctx_d;
      w_q       <= w_d;
      vars_q    <= vars_d;
      cnt_q     <= cnt_d;
      out_ctx_q <= out_ctx_d;
    end
  end

endmodule

// File: tb/tb_sha256_compressor.sv
// Randomized and directed bench for sha256_compressor with a word-array SHA-256 model.
module tb_sha256_compressor;

  localparam int unsigned UNROLL = 1;
  localparam int LAT = 64 / UNROLL + 1;

  localparam logic [31:0] KM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst;
  logic ctx_vld, ctx_rdy, w_vld, w_rdy, out_vld, out_rdy;
  sha256_pkg::ShaContext ctx, out_ctx;
  logic [63:0][31:0] w;

  int checks = 0;
  int failures = 0;
  logic [255:0] exp_q [$];

  logic [255:0] iv      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  logic [255:0] dig_abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic [255:0] dig_two = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_compressor #(.UNROLL(UNROLL)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctx_vld (ctx_vld),
    .ctx_rdy (ctx_rdy),
    .ctx     (ctx),
    .w_vld   (w_vld),
    .w_rdy   (w_rdy),
    .w       (w),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_ctx (out_ctx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0][31:0] expand(input logic [15:0][31:0] m);
    logic [63:0][31:0] r;
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) r[t] = m[t];
      else begin
        s0 = rotr(r[t-15], 7) ^ rotr(r[t-15], 18) ^ (r[t-15] >> 3);
        s1 = rotr(r[t-2], 17) ^ rotr(r[t-2], 19) ^ (r[t-2] >> 10);
        r[t] = r[t-16] + s0 + r[t-7] + s1;
      end
    end
    return r;
  endfunction

  function automatic logic [255:0] model(input logic [255:0] c, input logic [63:0][31:0] wv);
    logic [31:0] hv [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      hv[i] = c[255-32*i -: 32];
      v[i]  = hv[i];
    end
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KM[t] + wv[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + v[i];
    return r;
  endfunction

  task automatic check_ctx(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle the result is valid it must equal the oldest outstanding model value.
  always @(negedge clk) begin
    if (!rst && out_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out_vld: got out_vld=1 expected 0");
      end else begin
        check_ctx("out_ctx_model", out_ctx, exp_q[0]);
        check_bit("ctx_rdy_busy", ctx_rdy, 1'b0);
        check_bit("w_rdy_busy", w_rdy, 1'b0);
        if (out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // Offer ctx after cd cycles and w after wd cycles; returns just after the accept edge.
  task automatic send_inputs(input logic [255:0] c, input logic [63:0][31:0] wv,
                             input int cd, input int wd);
    int cyc = 0;
    bit cdone = 0, wdone = 0, xc, xw;
    ctx = c;
    w   = wv;
    exp_q.push_back(model(c, wv));
    while (!(cdone && wdone)) begin
      ctx_vld = !cdone && cyc >= cd;
      w_vld   = !wdone && cyc >= wd;
      @(negedge clk);
      if (wdone && !cdone) begin
        check_bit("w_rdy_after_w", w_rdy, 1'b0);
        check_bit("ctx_rdy_waiting", ctx_rdy, 1'b1);
      end
      if (cdone && !wdone) begin
        check_bit("ctx_rdy_after_ctx", ctx_rdy, 1'b0);
        check_bit("w_rdy_waiting", w_rdy, 1'b1);
      end
      xc = ctx_vld & ctx_rdy;
      xw = w_vld & w_rdy;
      tick();
      if (xc) cdone = 1;
      if (xw) wdone = 1;
      cyc++;
      if (cyc > 500) begin
        checks++;
        failures++;
        $display("FAIL input_timeout: got no accept expected accept within 500 cycles");
        break;
      end
    end
    ctx_vld = 1'b0;
    w_vld   = 1'b0;
  endtask

  // Wait for out_vld, check latency, backpressure for hold cycles, then accept.
  task automatic await_result(input int hold, input bit tied, output logic [255:0] res);
    int k = 0;
    @(negedge clk);
    while (!out_vld && k < 300) begin
      tick();
      @(negedge clk);
      k++;
    end
    check_int("latency", k, LAT);
    res = out_ctx;
    if (!tied) begin
      repeat (hold) begin
        tick();
        @(negedge clk);
        check_bit("out_vld_held", out_vld, 1'b1);
      end
      tick();
      out_rdy = 1'b1;
      @(negedge clk);
      tick();
      out_rdy = 1'b0;
    end else begin
      tick();
    end
    @(negedge clk);
    check_bit("out_vld_after_accept", out_vld, 1'b0);
    check_bit("ctx_rdy_idle", ctx_rdy, 1'b1);
    check_bit("w_rdy_idle", w_rdy, 1'b1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][31:0] m;
    logic [63:0][31:0] w_abc, w_rnd;
    logic [255:0] res, c_rnd;

    rst = 1'b1; ctx_vld = 1'b0; w_vld = 1'b0; out_rdy = 1'b0;
    ctx = '0; w = '0;
    m = '0;
    m[0] = 32'h61626380;
    m[15] = 32'h00000018;
    w_abc = expand(m);

    repeat (2) tick();
    @(negedge clk);
    check_bit("reset_ctx_rdy", ctx_rdy, 1'b0);
    check_bit("reset_w_rdy", w_rdy, 1'b0);
    check_bit("reset_out_vld", out_vld, 1'b0);
    check_ctx("reset_out_ctx", out_ctx, 256'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_bit("post_reset_ctx_rdy", ctx_rdy, 1'b1);
    check_bit("post_reset_w_rdy", w_rdy, 1'b1);
    tick();

    // "abc", both inputs in the same cycle
    send_inputs(iv, w_abc, 0, 0);
    await_result(0, 0, res);
    check_ctx("abc_digest", res, dig_abc);

    // schedule 10 cycles ahead of context, then the reverse order
    send_inputs(iv, w_abc, 10, 0);
    await_result(0, 0, res);
    check_ctx("abc_w_first", res, dig_abc);
    send_inputs(iv, w_abc, 0, 4);
    await_result(0, 0, res);
    check_ctx("abc_ctx_first", res, dig_abc);

    // backpressure
    send_inputs(iv, w_abc, 0, 0);
    await_result(20, 0, res);
    check_ctx("abc_backpressure", res, dig_abc);

    // two-block chain
    for (int t = 0; t < 14; t++) m[t] = 32'h61626364 + 32'h01010101 * t;
    m[14] = 32'h80000000;
    m[15] = 32'h00000000;
    send_inputs(iv, expand(m), 0, 0);
    await_result(1, 0, res);
    m = '0;
    m[15] = 32'h000001c0;
    send_inputs(res, expand(m), 1, 0);
    await_result(0, 0, res);
    check_ctx("two_block_digest", res, dig_two);

    // out_rdy tied high: ready again right after the result leaves
    out_rdy = 1'b1;
    send_inputs(iv, w_abc, 0, 0);
    await_result(0, 1, res);
    check_ctx("abc_tied_rdy", res, dig_abc);
    out_rdy = 1'b0;

    // reset at round 30 aborts the run
    send_inputs(iv, w_abc, 0, 0);
    repeat (30 / UNROLL) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_bit("abort_out_vld", out_vld, 1'b0);
    check_bit("abort_ctx_rdy", ctx_rdy, 1'b1);
    check_bit("abort_w_rdy", w_rdy, 1'b1);
    check_ctx("abort_out_ctx", out_ctx, 256'd0);
    repeat (100) tick();
    send_inputs(iv, w_abc, 0, 0);
    await_result(0, 0, res);
    check_ctx("abc_after_abort", res, dig_abc);

    // randomized contexts, schedules, arrival skew and backpressure
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++) c_rnd[32*i +: 32] = $urandom;
      for (int i = 0; i < 64; i++) w_rnd[i] = $urandom;
      send_inputs(c_rnd, w_rnd, $urandom_range(0, 12), $urandom_range(0, 12));
      await_result($urandom_range(0, 4), 0, res);
    end

    check_int("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
